id_ex_pipe_reg: RTL and testbench

Parametrised ID/EX pipeline stage register and the successor to the fixed-width ID/EX latch.
- Carries a control word, NUM_OPS data operands and NUM_REGS register specifiers from decode to execute.
- Uses a valid/ready handshake with a 2-entry skid buffer, so the stage sustains full throughput while in_ready stays registered.
- Hazard-unit stall and branch flush are native; a flushed or empty stage presents a NOP control bubble downstream.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/id_ex_pipe_reg_if.sv | 33 +++
 rtl/pipe_entry.sv | 15 +
 rtl/id_ex_pipe_reg.sv | 108 ++++++++++
 tb/tb_id_ex_pipe_reg.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and default widths for the ID/EX stage register
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_OPS  = 4;
  localparam int DEF_CTRL_W   = 13;
  localparam int DEF_REG_W    = 5;
  localparam int DEF_NUM_REGS = 3;
  localparam logic [DEF_CTRL_W-1:0] DEF_CTRL_NOP = 13'd1;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// rtl/id_ex_pipe_reg_if.sv - decode-side and execute-side handshake bundle of the ID/EX stage
interface id_ex_pipe_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_OPS  = DEF_NUM_OPS,
  parameter int CTRL_W   = DEF_CTRL_W,
  parameter int REG_W    = DEF_REG_W,
  parameter int NUM_REGS = DEF_NUM_REGS
);
  logic                      in_valid;
  logic                      in_ready;
  logic [CTRL_W-1:0]         in_ctrl;
  logic [NUM_OPS*DATA_W-1:0] in_ops;
  logic [NUM_REGS*REG_W-1:0] in_regs;
  logic                      stall;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [CTRL_W-1:0]         out_ctrl;
  logic [NUM_OPS*DATA_W-1:0] out_ops;
  logic [NUM_REGS*REG_W-1:0] out_regs;

  modport master (
    output in_valid, in_ctrl, in_ops, in_regs, stall, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_ops, out_regs
  );

  modport slave (
    input  in_valid, in_ctrl, in_ops, in_regs, stall, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_ops, out_regs
  );
endinterface

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - width-generic storage register with load enable and asynchronous clear
module pipe_entry #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
  end
endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX stage register with 2-entry skid buffer, stall and flush
// Optional ID_EX_PERF_EN adds bubble_cnt and stall_cnt outputs.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_OPS  = DEF_NUM_OPS,
  parameter int CTRL_W   = DEF_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_NOP = DEF_CTRL_NOP,
  parameter int REG_W    = DEF_REG_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic clk,
  input  logic reset,
  id_ex_pipe_reg_if.slave bus
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0] bubble_cnt,
  output logic [31:0] stall_cnt
`endif
);
  localparam int OPS_W  = NUM_OPS * DATA_W;
  localparam int REGS_W = NUM_REGS * REG_W;
  localparam int W      = CTRL_W + OPS_W + REGS_W;

  state_t       state, state_nxt;
  logic         in_ready_q;
  logic         in_fire, out_fire;
  logic         load_main, load_skid, main_from_skid;
  logic [W-1:0] in_word, main_d, main_q, skid_q;

  assign in_word  = {bus.in_ctrl, bus.in_ops, bus.in_regs};
  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = bus.out_valid & bus.out_ready & ~bus.stall;
  assign main_d   = main_from_skid ? skid_q : in_word;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (bus.flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (in_fire) begin
          state_nxt = FULL;
          load_main = 1'b1;
        end
        FULL: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            state_nxt = SKID;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        SKID: if (out_fire) begin
          state_nxt      = FULL;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // in_ready is looked ahead from the next state so it stays a flop output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != SKID);
    end
  end

  pipe_entry #(.W(W)) u_main (
    .clk(clk), .reset(reset), .load(load_main), .d(main_d), .q(main_q)
  );

  pipe_entry #(.W(W)) u_skid (
    .clk(clk), .reset(reset), .load(load_skid), .d(in_word), .q(skid_q)
  );

  // Bubbles carry a NOP and zero specifiers so forwarding compares never match
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_ctrl  = bus.out_valid ? main_q[W-1 -: CTRL_W] : CTRL_NOP;
  assign bus.out_ops   = main_q[REGS_W +: OPS_W];
  assign bus.out_regs  = bus.out_valid ? main_q[0 +: REGS_W] : '0;

`ifdef ID_EX_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (!bus.out_valid)            bubble_cnt <= bubble_cnt + 32'd1;
      if (bus.out_valid && bus.stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - randomized and directed bench for id_ex_pipe_reg against a queue model
module tb_id_ex_pipe_reg;
  typedef struct {
    logic [12:0]  ctrl;
    logic [127:0] ops;
    logic [14:0]  regs;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_pipe_reg_if bus ();

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt, stall_cnt;
  id_ex_pipe_reg dut (.clk(clk), .reset(reset), .bus(bus),
                      .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt));
`else
  id_ex_pipe_reg dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  int          total = 0;
  int          bad   = 0;
  beat_t       q[$];
  logic [127:0] last_ops;
  int unsigned bub_m, stl_m;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    b.ctrl = 13'($urandom);
    b.ops  = {$urandom, $urandom, $urandom, $urandom};
    b.regs = 15'($urandom);
    return b;
  endfunction

  task automatic check_all();
    chk("out_valid", 128'(bus.out_valid), 128'(q.size() > 0));
    chk("in_ready", 128'(bus.in_ready), 128'(q.size() < 2));
    chk("out_ctrl", 128'(bus.out_ctrl), (q.size() > 0) ? 128'(q[0].ctrl) : 128'(13'd1));
    chk("out_regs", 128'(bus.out_regs), (q.size() > 0) ? 128'(q[0].regs) : 128'(0));
    chk("out_ops", bus.out_ops, last_ops);
`ifdef ID_EX_PERF_EN
    chk("bubble_cnt", 128'(bubble_cnt), 128'(bub_m));
    chk("stall_cnt", 128'(stall_cnt), 128'(stl_m));
`endif
  endtask

  // Called at a negedge: drive one cycle of inputs, advance the model, check at the next negedge.
  task automatic cycle(input logic iv, input beat_t b, input logic ordy, input logic stl, input logic fl);
    logic fire_in, fire_out;
    bus.in_valid  = iv;
    bus.in_ctrl   = b.ctrl;
    bus.in_ops    = b.ops;
    bus.in_regs   = b.regs;
    bus.out_ready = ordy;
    bus.stall     = stl;
    bus.flush     = fl;
    @(posedge clk);
    fire_in  = iv && (q.size() < 2);
    fire_out = (q.size() > 0) && ordy && !stl;
    if (q.size() == 0) bub_m++;
    if (q.size() > 0 && stl) stl_m++;
    if (fl) q.delete();
    else begin
      if (fire_out) void'(q.pop_front());
      if (fire_in) q.push_back(b);
    end
    if (q.size() > 0) last_ops = q[0].ops;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.in_ctrl = '0; bus.in_ops = '0; bus.in_regs = '0;
    bus.out_ready = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic clear_model();
    q.delete();
    last_ops = '0;
    bub_m = 0;
    stl_m = 0;
  endtask

  beat_t b, nb, first;
`ifdef ID_EX_PERF_EN
  logic [31:0] bc0, sc0;
`endif

  initial begin
    reset = 1'b1;
    idle_inputs();
    clear_model();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all();

    // Streaming: 8 back-to-back beats with the consumer always ready
    for (int i = 0; i < 8; i++) begin
      b = rand_beat();
      cycle(1'b1, b, 1'b1, 1'b0, 1'b0);
      chk("stream_rdy", 128'(bus.in_ready), 128'(1));
      chk("stream_ctrl", 128'(bus.out_ctrl), 128'(b.ctrl));
    end
    cycle(1'b0, nb, 1'b1, 1'b0, 1'b0);

    // Skid fill under stall, then drain in order
    first = rand_beat(); first.ctrl = 13'h011;
    cycle(1'b1, first, 1'b0, 1'b0, 1'b0);
    nb = rand_beat(); nb.ctrl = 13'h0A4;
    cycle(1'b1, nb, 1'b1, 1'b1, 1'b0);
    chk("skid_rdy_low", 128'(bus.in_ready), 128'(0));
    chk("skid_head", 128'(bus.out_ctrl), 128'(13'h011));
    cycle(1'b0, nb, 1'b1, 1'b0, 1'b0);
    chk("skid_second", 128'(bus.out_ctrl), 128'(13'h0A4));
    chk("skid_rdy_high", 128'(bus.in_ready), 128'(1));
    cycle(1'b0, nb, 1'b1, 1'b0, 1'b0);

    // Flush while in SKID with a new beat offered
    cycle(1'b1, rand_beat(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, rand_beat(), 1'b0, 1'b0, 1'b0);
    chk("pre_flush_rdy", 128'(bus.in_ready), 128'(0));
    cycle(1'b1, rand_beat(), 1'b1, 1'b0, 1'b1);
    chk("flush_valid", 128'(bus.out_valid), 128'(0));
    chk("flush_ctrl", 128'(bus.out_ctrl), 128'(13'd1));
    chk("flush_regs", 128'(bus.out_regs), 128'(0));
    chk("flush_rdy", 128'(bus.in_ready), 128'(1));

    // Bubble: empty stage with consumer ready for 3 cycles
`ifdef ID_EX_PERF_EN
    bc0 = bubble_cnt; sc0 = stall_cnt;
`endif
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, rand_beat(), 1'b1, 1'b0, 1'b0);
      chk("bubble_ctrl", 128'(bus.out_ctrl), 128'(13'd1));
    end
`ifdef ID_EX_PERF_EN
    chk("bubble_delta", 128'(bubble_cnt - bc0), 128'(3));
    chk("stall_delta", 128'(stall_cnt - sc0), 128'(0));
`endif

    // Asynchronous reset mid-SKID
    cycle(1'b1, rand_beat(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, rand_beat(), 1'b1, 1'b1, 1'b0);
    chk("rst_pre_valid", 128'(bus.out_valid), 128'(1));
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_ctrl", 128'(bus.out_ctrl), 128'(13'd1));
    chk("rst_regs", 128'(bus.out_regs), 128'(0));
    chk("rst_ops", bus.out_ops, 128'(0));
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    check_all();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) < 7, rand_beat(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
